// File: rtl/mux_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial front end of the 8:1 mux.
package mux_serializer_pkg;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  function automatic logic [SEL_W-1:0] first_sel(input bit msb_first);
    return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
  endfunction

  function automatic logic [SEL_W-1:0] last_sel(input bit msb_first);
    return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
  endfunction

endpackage

// File: rtl/mux8to1.sv
// Plain 8:1 multiplexer: Y is input bit I[S].
module mux8to1 (
  input  logic [7:0] I,
  input  logic [2:0] S,
  output logic       Y
);

  assign Y = I[S];

endmodule

// File: rtl/mux_serializer.sv
// Holds an accepted byte and sweeps the mux select across it, DIV clocks per bit,
// with a frame-done strobe in the final cycle and zero-gap back-to-back frames.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              pause,
  output logic [SEL_W-1:0]  sel,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done
);

  // DIV=1 would give a zero-width divider; keep one bit that simply stays at 0.
  localparam int                CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [SEL_W-1:0]  FIRST    = first_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0]  LAST     = last_sel(MSB_FIRST);

  state_t            state;
  logic [WORD_W-1:0] hold;
  logic [CNT_W-1:0]  div_cnt;
  logic              bit_end;
  logic              frame_last;
  logic              accept;
  logic              mux_y;

  assign bit_end    = (div_cnt == DIV_LAST);
  assign frame_last = (state == SHIFT) && (sel == LAST) && bit_end && !pause;
  assign frame_done = frame_last;
  assign in_ready   = (state == IDLE) || frame_last;
  assign accept     = in_valid && in_ready;
  assign ser_valid  = (state == SHIFT);

  mux8to1 u_mux (
    .I (hold),
    .S (sel),
    .Y (mux_y)
  );

  assign ser_out = mux_y && ser_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hold    <= '0;
      sel     <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold    <= in_data;
            sel     <= FIRST;
            div_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!pause) begin
            if (bit_end) begin
              div_cnt <= '0;
              if (sel == LAST) begin
                // A word taken in the final cycle starts the next frame without a gap.
                if (accept) begin
                  hold <= in_data;
                  sel  <= FIRST;
                end else begin
                  state <= IDLE;
                end
              end else if (MSB_FIRST) begin
                sel <= sel - 1'b1;
              end else begin
                sel <= sel + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
